// File: rtl/softmax_divider_16_if.sv
// ============================================================================
// Module      : softmax_divider_16_if
// Description : Data/handshake bundle between the softmax stages and the divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface softmax_divider_16_if #(
    parameter int data_size = 16
) ();
    logic [data_size-1:0] exp_data_i;
    logic                 exp_data_valid_i;
    logic [data_size-1:0] sum_data_i;
    logic                 sum_data_valid_i;
    logic                 clear_i;
    logic [data_size-1:0] div_data_o;
    logic                 div_data_valid_o;
    logic                 div_done_o;
    logic                 overflow_o;

    modport master (
        output exp_data_i, exp_data_valid_i, sum_data_i, sum_data_valid_i, clear_i,
        input  div_data_o, div_data_valid_o, div_done_o, overflow_o
    );

    modport slave (
        input  exp_data_i, exp_data_valid_i, sum_data_i, sum_data_valid_i, clear_i,
        output div_data_o, div_data_valid_o, div_done_o, overflow_o
    );
endinterface

`default_nettype wire

// File: rtl/softmax_divider_16.sv
// ============================================================================
// Module      : softmax_divider_16
// Description : Buffers exp values, then divides each by the final sum (Q4.12).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module softmax_divider_16 #(
    parameter int data_size = 16,
    parameter int frac_size = 12,
    parameter int depth     = 16
) (
    input  wire logic             clock_i,
    input  wire logic             reset_n_i,
    softmax_divider_16_if.slave   bus
);

    localparam int W    = data_size + frac_size;
    localparam int AW   = (depth > 1) ? $clog2(depth) : 1;
    localparam int CNTW = AW + 1;
    localparam int BW   = $clog2(W);

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_LOAD    = 3'd1,
        S_DIVIDE  = 3'd2,
        S_OUTPUT  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [data_size-1:0] mem_q [depth];
    logic [CNTW-1:0]      count_q, count_d;
    logic [CNTW-1:0]      index_q, index_d;
    logic [data_size-1:0] sum_q, sum_d;
    logic [W-1:0]         dvd_q, dvd_d;
    logic [data_size-1:0] rem_q, rem_d;
    logic [BW-1:0]        step_q, step_d;
    logic [data_size-1:0] div_data_q, div_data_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic                 w_full;
    logic                 w_wr_accept;
    logic [data_size:0]   w_shift;
    logic [data_size:0]   w_trial;
    logic                 w_qbit;
    logic                 w_sat;

    assign w_full      = (count_q == CNTW'(depth));
    assign w_wr_accept = (state_q == S_COLLECT) && bus.exp_data_valid_i && !w_full && !bus.clear_i;

    // Restoring step: the dividend register shifts its MSB into the remainder
    // while quotient bits fill in from the LSB end.
    assign w_shift = {rem_q, dvd_q[W-1]};
    assign w_trial = w_shift - {1'b0, sum_q};
    assign w_qbit  = ~w_trial[data_size];
    assign w_sat   = (|dvd_q[W-1:data_size]) || (sum_q == '0);

    always_ff @(posedge clock_i) begin
        if (w_wr_accept) begin
            mem_q[count_q[AW-1:0]] <= bus.exp_data_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_COLLECT;
            count_q    <= '0;
            index_q    <= '0;
            sum_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            step_q     <= '0;
            div_data_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            sum_q      <= sum_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            step_q     <= step_d;
            div_data_q <= div_data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        sum_d      = sum_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        step_d     = step_q;
        div_data_d = div_data_q;
        valid_d    = 1'b0;
        done_d     = done_q;
        ovf_d      = ovf_q;

        if (bus.clear_i) begin
            state_d    = S_COLLECT;
            count_d    = '0;
            index_d    = '0;
            step_d     = '0;
            div_data_d = '0;
            done_d     = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (bus.exp_data_valid_i) begin
                        if (w_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    if (bus.sum_data_valid_i) begin
                        sum_d   = bus.sum_data_i;
                        state_d = (count_d == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    dvd_d   = {mem_q[index_q[AW-1:0]], {frac_size{1'b0}}};
                    rem_d   = '0;
                    step_d  = '0;
                    state_d = S_DIVIDE;
                end
                S_DIVIDE: begin
                    rem_d  = w_qbit ? w_trial[data_size-1:0] : w_shift[data_size-1:0];
                    dvd_d  = {dvd_q[W-2:0], w_qbit};
                    step_d = step_q + 1'b1;
                    if (step_q == BW'(W - 1)) begin
                        state_d = S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    div_data_d = w_sat ? '1 : dvd_q[data_size-1:0];
                    valid_d    = 1'b1;
                    index_d    = index_q + 1'b1;
                    state_d    = (index_d < count_q) ? S_LOAD : S_DONE;
                end
                S_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = S_COLLECT;
                end
            endcase
        end
    end

    assign bus.div_data_o       = div_data_q;
    assign bus.div_data_valid_o = valid_q;
    assign bus.div_done_o       = done_q;
    assign bus.overflow_o       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_softmax_divider_16.sv
// ============================================================================
// Module      : tb_softmax_divider_16
// Description : Directed self-checking bench for softmax_divider_16.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_softmax_divider_16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   s_e;

    logic [15:0] q_data[$];
    int          q_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    softmax_divider_16_if #(.data_size(16)) bus ();

    softmax_divider_16 #(
        .data_size(16),
        .frac_size(12),
        .depth    (16)
    ) dut (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    always @(negedge clk) begin
        if (bus.div_data_valid_o) begin
            q_data.push_back(bus.div_data_o);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [15:0] v);
        bus.exp_data_i       = v;
        bus.exp_data_valid_i = 1'b1;
        tick();
        bus.exp_data_valid_i = 1'b0;
    endtask

    // sum stays asserted afterwards, as a level from the adder stage would
    task automatic start_sum(input logic [15:0] s);
        bus.sum_data_i       = s;
        bus.sum_data_valid_i = 1'b1;
        tick();
        s_e = cyc;
    endtask

    task automatic do_clear();
        bus.clear_i          = 1'b1;
        bus.sum_data_valid_i = 1'b0;
        tick();
        bus.clear_i = 1'b0;
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic check_results(input string tag, input logic [15:0] exp_v[$]);
        check({tag, "_count"}, q_data.size(), exp_v.size());
        for (int k = 0; k < exp_v.size() && k < q_data.size(); k++) begin
            check($sformatf("%s_data%0d", tag, k), q_data[k], exp_v[k]);
            check($sformatf("%s_lat%0d", tag, k), q_cyc[k] - s_e, 30 * (k + 1));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_data"},  bus.div_data_o,       0);
        check({tag, "_valid"}, bus.div_data_valid_o, 0);
        check({tag, "_done"},  bus.div_done_o,       0);
        check({tag, "_ovf"},   bus.overflow_o,       0);
    endtask

    initial begin
        logic [15:0] ev[$];
        bus.exp_data_i       = '0;
        bus.exp_data_valid_i = 1'b0;
        bus.sum_data_i       = '0;
        bus.sum_data_valid_i = 1'b0;
        bus.clear_i          = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        // single element, exact pulse timing, done afterwards, no restart
        write(16'h1000);
        start_sum(16'h4000);
        repeat (29) tick();
        check("t1_pre_valid", bus.div_data_valid_o, 0);
        tick();
        check("t1_valid", bus.div_data_valid_o, 1);
        check("t1_data", bus.div_data_o, 16'h0400);
        tick();
        check("t1_pulse_len", bus.div_data_valid_o, 0);
        check("t1_done", bus.div_done_o, 1);
        repeat (40) tick();
        check("t1_no_restart", q_data.size(), 1);
        check("t1_hold", bus.div_data_o, 16'h0400);
        do_clear();
        check("t1_clear_done", bus.div_done_o, 0);

        // three elements, last write coincides with sum
        write(16'h1000);
        write(16'h2000);
        bus.exp_data_i       = 16'h1000;
        bus.exp_data_valid_i = 1'b1;
        start_sum(16'h4000);
        bus.exp_data_valid_i = 1'b0;
        repeat (95) tick();
        ev = '{16'h0400, 16'h0800, 16'h0400};
        check_results("t2", ev);
        do_clear();

        // overflow: 17 writes into 16 entries
        for (int i = 0; i < 16; i++) write(16'((i + 1) << 8));
        check("t3_no_ovf", bus.overflow_o, 0);
        write(16'h1100);
        check("t3_ovf", bus.overflow_o, 1);
        start_sum(16'h1000);
        repeat (16 * 30 + 10) tick();
        check("t3_count", q_data.size(), 16);
        if (q_data.size() == 16) begin
            check("t3_first", q_data[0], 16'h0100);
            check("t3_last", q_data[15], 16'h1000);
        end
        check("t3_ovf_sticky", bus.overflow_o, 1);
        do_clear();
        check("t3_ovf_clr", bus.overflow_o, 0);

        // zero sum saturates
        write(16'h1000);
        write(16'h0800);
        start_sum(16'h0000);
        repeat (65) tick();
        ev = '{16'hFFFF, 16'hFFFF};
        check_results("t4", ev);
        do_clear();

        // oversize quotient saturates
        write(16'hF000);
        start_sum(16'h0001);
        repeat (35) tick();
        ev = '{16'hFFFF};
        check_results("t5", ev);
        do_clear();

        // fractional results
        write(16'h3000);
        write(16'h1000);
        start_sum(16'h3000);
        repeat (65) tick();
        ev = '{16'h1000, 16'h0555};
        check_results("t6", ev);
        do_clear();

        // sum with no writes goes straight to done
        start_sum(16'h4000);
        tick();
        check("t7_done", bus.div_done_o, 1);
        repeat (40) tick();
        check("t7_no_pulse", q_data.size(), 0);
        do_clear();

        // clear in the 10th divide cycle
        write(16'h1000);
        start_sum(16'h4000);
        repeat (10) tick();
        do_clear();
        repeat (40) tick();
        check("t8_no_pulse", q_data.size(), 0);
        check_idle("t8");
        write(16'h0800);
        start_sum(16'h1000);
        repeat (35) tick();
        ev = '{16'h0800};
        check_results("t8_fresh", ev);
        do_clear();

        // reset in the 10th divide cycle
        write(16'h1000);
        start_sum(16'h4000);
        repeat (10) tick();
        rst_n                = 1'b0;
        bus.sum_data_valid_i = 1'b0;
        #1;
        check_idle("t9_rst");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("t9_no_pulse", q_data.size(), 0);
        check_idle("t9");
        write(16'h0800);
        start_sum(16'h1000);
        repeat (35) tick();
        ev = '{16'h0800};
        check_results("t9_fresh", ev);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/softmax_divider_16.md
SOFTMAX_DIVIDER_16 -- requirements
Module: softmax_divider_16

Interface
REQ-001 SHALL have parameter data_size, default 16, width of exp values, sum and quotient.
REQ-002 SHALL have parameter frac_size, default 12, number of fractional bits in exp values and results (Q4.12 unsigned).
REQ-003 SHALL have parameter depth, default 16, number of exp entries buffered; power of two.
REQ-004 SHALL have port clock_i, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port exp_data_i, input, data_size, exp value from exponent stage.
REQ-007 SHALL have port exp_data_valid_i, input, 1, qualifies exp_data_i for one write per cycle.
REQ-008 SHALL have port sum_data_i, input, data_size, accumulated exp sum from adder stage, same Q format.
REQ-009 SHALL have port sum_data_valid_i, input, 1, level; high once the sum is final.
REQ-010 SHALL have port clear_i, input, 1, synchronous restart request.
REQ-011 SHALL have port div_data_o, output, data_size, softmax result exp/sum in Q4.12.
REQ-012 SHALL have port div_data_valid_o, output, 1, one-cycle pulse per result.
REQ-013 SHALL have port div_done_o, output, 1, high after the last result until clear or reset.
REQ-014 SHALL have port overflow_o, output, 1, sticky; a write was dropped because the buffer was full.

Function
REQ-015 SHALL implement FSM states COLLECT, LOAD, DIVIDE, OUTPUT, DONE.
REQ-016 In COLLECT, each exp_data_valid_i cycle SHALL write exp_data_i to buffer[count] and increment count (0..depth).
REQ-017 Writes with count == depth SHALL be dropped and SHALL set overflow_o; count does not wrap.
REQ-018 exp_data_valid_i outside COLLECT SHALL be ignored without setting overflow_o.
REQ-019 In COLLECT with sum_data_valid_i high, the FSM SHALL latch sum_data_i and go to LOAD, or to DONE if count is 0 after that cycle's write.
REQ-020 If write and sum_data_valid_i coincide, the write SHALL be accepted and included in the division set.
REQ-021 LOAD (1 cycle) SHALL fetch buffer[index] (index starting at 0) and form dividend = exp << frac_size (data_size+frac_size bits).
REQ-022 DIVIDE SHALL run restoring division, one quotient bit per cycle, exactly data_size+frac_size cycles (28 by default).
REQ-023 OUTPUT (1 cycle) SHALL drive div_data_o = floor(dividend/sum), pulse div_data_valid_o, and increment index.
REQ-024 From OUTPUT, the FSM SHALL return to LOAD if index < count, else go to DONE.
REQ-025 Per-element latency SHALL be data_size+frac_size+2 cycles from LOAD entry to valid pulse (30 by default); results SHALL emerge in write order.
REQ-026 A quotient exceeding 2^data_size-1 SHALL saturate to all-ones.
REQ-027 A latched sum of 0 SHALL yield all-ones for every element with unchanged timing.
REQ-028 div_data_o SHALL hold its last value between pulses.
REQ-029 In DONE, div_done_o SHALL be 1; sum_data_valid_i staying high SHALL NOT restart division.
REQ-030 clear_i in any state SHALL return to COLLECT, zero count, index, done and overflow, and discard any in-progress division with no further valid pulse; buffer contents need not be cleared.
REQ-031 clear_i SHALL take priority over writes in the same cycle.

Reset
REQ-032 reset_n_i low SHALL immediately force COLLECT, count = index = 0, div_data_o = 0, div_data_valid_o = 0, div_done_o = 0, overflow_o = 0, latched sum = 0.
REQ-033 Reset asserted mid-DIVIDE SHALL abort the division with no valid pulse; operation resumes from COLLECT on the first clock edge after release.

Verification
REQ-034 Write 0x1000 once, sum 0x4000 -> one valid pulse 30 cycles after LOAD entry, div_data_o = 0x0400, div_done_o = 1 on the next cycle.
REQ-035 Write 0x1000, 0x2000, 0x1000, sum 0x4000 -> results 0x0400, 0x0800, 0x0400 in order, pulses 30 cycles apart.
REQ-036 Write 17 values with depth 16 -> overflow_o = 1 on the 17th write; exactly 16 results are produced.
REQ-037 Sum 0x0000 with two writes, and separately exp 0xF000 with sum 0x0001 -> div_data_o = 0xFFFF for every result.
REQ-038 sum_data_valid_i with no writes -> direct to DONE, div_done_o = 1, no valid pulse.
REQ-039 Reset or clear_i asserted at the 10th DIVIDE cycle -> no pulse, all outputs 0; then a fresh set of 0x0800 with sum 0x1000 -> 0x0800.
